regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_mp_sb.sv | 142 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with per-register busy scoreboard
//
// Purpose: NREGS x XLEN register file with NRD combinational read ports and
// NWR write ports. Same-cycle writes are forwarded to the read ports. A busy
// bit per register tracks in-flight producers: issue sets it, writeback
// clears it, flush clears all.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   raddr_i      read addresses, port p = [p*AW +: AW]
//   rdata_o      read data, port p = [p*XLEN +: XLEN]
//   rbusy_o      busy status of each read register (0 when forwarded)
//   we_i         write enables, one per write port
//   waddr_i      write addresses, port w = [w*AW +: AW]
//   wdata_i      write data, port w = [w*XLEN +: XLEN]
//   issue_i      mark issue_addr_i busy
//   issue_addr_i destination register of the issued producer
//   flush_i      clear all busy bits
//   busy_o       registered busy vector

module regfile_mp_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr_i,
    output logic [NRD*XLEN-1:0]         rdata_o,
    output logic [NRD-1:0]              rbusy_o,
    input  logic [NWR-1:0]              we_i,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr_i,
    input  logic [NWR*XLEN-1:0]         wdata_i,
    input  logic                        issue_i,
    input  logic [$clog2(NREGS)-1:0]    issue_addr_i,
    input  logic                        flush_i,
    output logic [NREGS-1:0]            busy_o
);

    localparam int AW = $clog2(NREGS);

    // An address is usable when it names an existing register and is not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0]  regs   [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NWR-1:0]   wr_ok;
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic             issue_ok;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wr_ok[w] = we_i[w] && addr_ok(waddr_i[w*AW +: AW]);
        end
    end

    assign issue_ok = issue_i && addr_ok(issue_addr_i);

    // Per-register write decode. Ports are scanned in ascending order so the
    // highest-index matching port is the one left in wr_val. Both the storage
    // update and the read bypass use this single result, so they always agree.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_ok[w] && (waddr_i[w*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Issue beats a same-cycle writeback: the write belongs to the older
    // producer, the newly issued one still has to complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else if (flush_i) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (issue_ok && (issue_addr_i == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = raddr_i[p*AW +: AW];

        // A register being written this cycle reads its new value and is not
        // reported busy: the consumer gets the data it was waiting for.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (addr_ok(ra)) begin
                if (wr_hit[ra]) begin
                    rd = wr_val[ra];
                end else begin
                    rd = regs[ra];
                    rb = busy_q[ra];
                end
            end
        end

        assign rdata_o[p*XLEN +: XLEN] = rd;
        assign rbusy_o[p]              = rb;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 32 registers, 2 read, 2 write ports
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [31:0] busy;

    // Non-power-of-two configuration: 24 registers
    logic [9:0]  raddr_s;
    logic [63:0] rdata_s;
    logic [1:0]  rbusy_s;
    logic [1:0]  we_s;
    logic [9:0]  waddr_s;
    logic [63:0] wdata_s;
    logic        issue_s;
    logic [4:0]  issue_addr_s;
    logic        flush_s;
    logic [23:0] busy_s;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_R0(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .issue_i(issue), .issue_addr_i(issue_addr), .flush_i(flush),
        .busy_o(busy)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .ZERO_R0(1)) dut24 (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(raddr_s), .rdata_o(rdata_s), .rbusy_o(rbusy_s),
        .we_i(we_s), .waddr_i(waddr_s), .wdata_i(wdata_s),
        .issue_i(issue_s), .issue_addr_i(issue_addr_s), .flush_i(flush_s),
        .busy_o(busy_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we = '0; issue = 1'b0; flush = 1'b0;
        we_s = '0; issue_s = 1'b0; flush_s = 1'b0;
    endtask

    initial begin
        raddr = '0; waddr = '0; wdata = '0; issue_addr = '0;
        raddr_s = '0; waddr_s = '0; wdata_s = '0; issue_addr_s = '0;
        idle();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_busy24", 64'(busy_s), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            check("rst_rdata", rdata, 64'h0);
            check("rst_rbusy", 64'(rbusy), 64'h0);
        end

        // Same-register write conflict: highest port wins, forwarded and stored
        @(negedge clk);
        raddr[4:0] = 5'd5;
        we = 2'b11; waddr = {5'd5, 5'd5};
        wdata = {32'h5555_0002, 32'hAAAA_0001};
        #1 check("conflict_fwd", 64'(rdata[31:0]), 64'h5555_0002);
        @(negedge clk);
        we = 2'b00;
        #1 check("conflict_stored", 64'(rdata[31:0]), 64'h5555_0002);

        // Two ports writing different registers
        @(negedge clk);
        we = 2'b11; waddr = {5'd11, 5'd10};
        wdata = {32'hBBBB_000B, 32'hAAAA_000A};
        @(negedge clk);
        we = 2'b00; raddr = {5'd11, 5'd10};
        #1 check("dual_write", rdata, {32'hBBBB_000B, 32'hAAAA_000A});

        // Issue r7: busy not visible in the issue cycle, visible next cycle
        @(negedge clk);
        issue = 1'b1; issue_addr = 5'd7; raddr[4:0] = 5'd7;
        #1 check("issue_same_cycle_rbusy", 64'(rbusy[0]), 64'h0);
        @(negedge clk);
        issue = 1'b0;
        #1 check("issue_rbusy", 64'(rbusy[0]), 64'h1);
        check("issue_busy7", 64'(busy[7]), 64'h1);
        // Writeback r7: forwarded, rbusy masked, busy_o clears next cycle
        @(negedge clk);
        we = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h0000_1234;
        #1 check("wb_rbusy", 64'(rbusy[0]), 64'h0);
        check("wb_fwd", 64'(rdata[31:0]), 64'h1234);
        check("wb_busy7_still", 64'(busy[7]), 64'h1);
        @(negedge clk);
        we = 2'b00;
        #1 check("wb_busy7_clear", 64'(busy[7]), 64'h0);
        check("wb_stored", 64'(rdata[31:0]), 64'h1234);

        // Issue and write r3 in the same cycle: issue wins, data stored
        @(negedge clk);
        issue = 1'b1; issue_addr = 5'd3;
        we = 2'b10; waddr[9:5] = 5'd3; wdata[63:32] = 32'hCAFE_F00D;
        @(negedge clk);
        idle(); raddr[9:5] = 5'd3;
        #1 check("iw_busy3", 64'(busy[3]), 64'h1);
        check("iw_data", 64'(rdata[63:32]), 64'hCAFE_F00D);
        check("iw_rbusy", 64'(rbusy[1]), 64'h1);

        // Register 0 is hardwired zero and never busy
        @(negedge clk);
        we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFF_FFFF;
        issue = 1'b1; issue_addr = 5'd0; raddr[4:0] = 5'd0;
        #1 check("r0_fwd", 64'(rdata[31:0]), 64'h0);
        check("r0_rbusy", 64'(rbusy[0]), 64'h0);
        @(negedge clk);
        idle();
        #1 check("r0_busy", 64'(busy[0]), 64'h0);
        check("r0_stored", 64'(rdata[31:0]), 64'h0);

        // Busy on r1..r4 (r3 still busy), then flush with concurrent issue
        for (int a = 1; a <= 4; a++) begin
            @(negedge clk);
            issue = 1'b1; issue_addr = 5'(a);
        end
        @(negedge clk);
        idle();
        #1 check("busy_r1_r4", 64'(busy), 64'h1E);
        @(negedge clk);
        flush = 1'b1; issue = 1'b1; issue_addr = 5'd2;
        @(negedge clk);
        idle();
        #1 check("flush_busy", 64'(busy), 64'h0);

        // NREGS=24: out-of-range write/read/issue ignored, last register works
        @(negedge clk);
        we_s = 2'b11; waddr_s = {5'd23, 5'd30};
        wdata_s = {32'h0000_0077, 32'hDEAD_BEEF};
        issue_s = 1'b1; issue_addr_s = 5'd30;
        raddr_s[4:0] = 5'd30;
        #1 check("oor_fwd", 64'(rdata_s[31:0]), 64'h0);
        @(negedge clk);
        idle(); raddr_s = {5'd23, 5'd30};
        #1 check("oor_read", rdata_s, {32'h0000_0077, 32'h0});
        check("oor_busy", 64'(busy_s), 64'h0);
        for (int a = 0; a < 32; a++) begin
            if (a != 23) begin
                raddr_s[4:0] = 5'(a);
                #1 check("oor_unchanged", 64'(rdata_s[31:0]), 64'h0);
            end
        end

        // Mid-burst asynchronous reset
        @(negedge clk);
        issue_s = 1'b1; issue_addr_s = 5'd6;
        issue = 1'b1; issue_addr = 5'd8;
        we = 2'b01; waddr[4:0] = 5'd12; wdata[31:0] = 32'h0000_0099;
        @(negedge clk);
        issue_s = 1'b0; issue = 1'b0;
        we = 2'b01; waddr[4:0] = 5'd13; wdata[31:0] = 32'h0000_0055;
        #1 check("pre_rst_busy6", 64'(busy_s[6]), 64'h1);
        check("pre_rst_busy8", 64'(busy[8]), 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        raddr_s = {5'd23, 5'd6};
        raddr = {5'd12, 5'd5};
        #1 check("midrst_rdata24", rdata_s, 64'h0);
        check("midrst_rbusy24", 64'(rbusy_s), 64'h0);
        check("midrst_busy24", 64'(busy_s), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_rdata", rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        we_s = 2'b01; waddr_s[4:0] = 5'd9; wdata_s[31:0] = 32'h0000_4242;
        @(negedge clk);
        idle(); raddr_s[4:0] = 5'd9;
        #1 check("post_rst_write", 64'(rdata_s[31:0]), 64'h4242);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
